// File: rtl/symbol_loop_filter_pi.sv
// rtl/symbol_loop_filter_pi.sv - registered PI loop filter for symbol timing recovery
// Two-stage pipeline: gain products, then integrator update with anti-windup and rounded, saturated output.
module symbol_loop_filter_pi #(
    parameter int SYM_WIDTH = 1,
    parameter int INT_WIDTH = 1,
    parameter int DEC_WIDTH = 14,
    localparam int W = SYM_WIDTH + INT_WIDTH + DEC_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                err_valid,
    input  logic signed [W-1:0] err,
    input  logic signed [W-1:0] c1,
    input  logic signed [W-1:0] c2,
    input  logic                mode,
    input  logic                freeze,
    input  logic                clear,
    output logic signed [W-1:0] ctrl,
    output logic                ctrl_valid,
    output logic signed [W-1:0] integ,
    output logic                sat
);

    localparam int P = 2 * W;
    localparam int A = 2 * W + 1;
    localparam int E = A + 1;

    // Integrator bounds equal the output range expressed at internal precision.
    localparam logic signed [E-1:0] I_MAX =
        $signed({{(E-W+1){1'b0}}, {(W-1){1'b1}}}) <<< DEC_WIDTH;
    localparam logic signed [E-1:0] I_MIN =
        $signed({{(E-W+1){1'b1}}, {(W-1){1'b0}}}) <<< DEC_WIDTH;
    localparam logic signed [E-1:0] W_MAX = $signed({{(E-W+1){1'b0}}, {(W-1){1'b1}}});
    localparam logic signed [E-1:0] W_MIN = $signed({{(E-W+1){1'b1}}, {(W-1){1'b0}}});
    localparam logic signed [E-1:0] RND =
        $signed({{(E-DEC_WIDTH){1'b0}}, 1'b1, {(DEC_WIDTH-1){1'b0}}});

    // Returns {clamped, value}: round-half-up to W bits, then saturate.
    function automatic logic [W:0] round_sat(input logic signed [E-1:0] x);
        logic signed [E-1:0] sh;
        logic [W:0]          res;
        sh = (x + RND) >>> DEC_WIDTH;
        if (sh > W_MAX) begin
            res = {1'b1, W_MAX[W-1:0]};
        end else if (sh < W_MIN) begin
            res = {1'b1, W_MIN[W-1:0]};
        end else begin
            res = {1'b0, sh[W-1:0]};
        end
        return res;
    endfunction

    logic signed [P-1:0] p1_q, p2_q;
    logic                v1_q;
    logic signed [A-1:0] acc_q;
    logic signed [W-1:0] ctrl_q, integ_q;
    logic                ctrl_valid_q, sat_q;

    logic signed [E-1:0] acc_ext, p1_ext, p2_ext, sum_i, s_sum;
    logic signed [A-1:0] acc_d;
    logic signed [E-1:0] acc_d_ext;
    logic                iclamp;
    logic [W:0]          ctrl_res, integ_res;
    logic signed [W-1:0] ctrl_d, integ_d;
    logic                sat_d;

    always_comb begin
        acc_ext = $signed({acc_q[A-1], acc_q});
        p1_ext  = $signed({{(E-P){p1_q[P-1]}}, p1_q});
        p2_ext  = $signed({{(E-P){p2_q[P-1]}}, p2_q});
        sum_i   = acc_ext + p2_ext;
        acc_d   = acc_q;
        iclamp  = 1'b0;
        if (!mode && !freeze) begin
            if (sum_i > I_MAX) begin
                acc_d  = I_MAX[A-1:0];
                iclamp = 1'b1;
            end else if (sum_i < I_MIN) begin
                acc_d  = I_MIN[A-1:0];
                iclamp = 1'b1;
            end else begin
                acc_d  = sum_i[A-1:0];
            end
        end
        acc_d_ext = $signed({acc_d[A-1], acc_d});
        // Proportional-only mode leaves the integrator out of the sum but keeps its state.
        s_sum     = mode ? p1_ext : (p1_ext + acc_d_ext);
        ctrl_res  = round_sat(s_sum);
        integ_res = round_sat(acc_d_ext);
        ctrl_d    = ctrl_res[W-1:0];
        integ_d   = integ_res[W-1:0];
        sat_d     = iclamp | ctrl_res[W] | integ_res[W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_q         <= '0;
            p2_q         <= '0;
            v1_q         <= 1'b0;
            acc_q        <= '0;
            ctrl_q       <= '0;
            integ_q      <= '0;
            ctrl_valid_q <= 1'b0;
            sat_q        <= 1'b0;
        end else if (clear) begin
            p1_q         <= '0;
            p2_q         <= '0;
            v1_q         <= 1'b0;
            acc_q        <= '0;
            ctrl_q       <= '0;
            integ_q      <= '0;
            ctrl_valid_q <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            v1_q         <= err_valid;
            ctrl_valid_q <= v1_q;
            if (err_valid) begin
                // Sign-extended operands make the low P bits equal the signed product.
                p1_q <= $signed({{W{c1[W-1]}}, c1} * {{W{err[W-1]}}, err});
                p2_q <= $signed({{W{c2[W-1]}}, c2} * {{W{err[W-1]}}, err});
            end
            if (v1_q) begin
                acc_q   <= acc_d;
                ctrl_q  <= ctrl_d;
                integ_q <= integ_d;
                sat_q   <= sat_d;
            end
        end
    end

    assign ctrl       = ctrl_q;
    assign integ      = integ_q;
    assign ctrl_valid = ctrl_valid_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_symbol_loop_filter_pi.sv
// tb/tb_symbol_loop_filter_pi.sv - self-checking bench for symbol_loop_filter_pi
module tb_symbol_loop_filter_pi;

    localparam int W = 16;
    localparam int D = 14;
    localparam longint I_MAX = 64'sd32767 * 64'sd16384;
    localparam longint I_MIN = -64'sd32768 * 64'sd16384;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                err_valid = 1'b0;
    logic signed [W-1:0] err = '0;
    logic signed [W-1:0] c1 = '0;
    logic signed [W-1:0] c2 = '0;
    logic                mode = 1'b0;
    logic                freeze = 1'b0;
    logic                clear = 1'b0;
    logic signed [W-1:0] ctrl;
    logic                ctrl_valid;
    logic signed [W-1:0] integ;
    logic                sat;

    int n_tests = 0;
    int n_fail  = 0;

    symbol_loop_filter_pi #(.SYM_WIDTH(1), .INT_WIDTH(1), .DEC_WIDTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .err_valid(err_valid), .err(err), .c1(c1), .c2(c2),
        .mode(mode), .freeze(freeze), .clear(clear), .ctrl(ctrl), .ctrl_valid(ctrl_valid),
        .integ(integ), .sat(sat)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic longint rnd_sat(input longint x, output bit clamped);
        longint r;
        r = (x + (64'sd1 <<< (D - 1))) >>> D;
        clamped = 1'b0;
        if (r > 32767) begin r = 32767; clamped = 1'b1; end
        if (r < -32768) begin r = -32768; clamped = 1'b1; end
        return r;
    endfunction

    task automatic do_strobe(input logic signed [W-1:0] e, g1, g2, input logic md, fz,
                             output logic vmid, vout, output logic signed [W-1:0] oc, oi,
                             output logic os);
        @(negedge clk);
        err_valid = 1'b1; err = e; c1 = g1; c2 = g2; mode = md; freeze = fz;
        @(negedge clk);
        err_valid = 1'b0;
        vmid = ctrl_valid;
        @(negedge clk);
        vout = ctrl_valid; oc = ctrl; oi = integ; os = sat;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; mode = 1'b0; freeze = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (ctrl !== 16'sd0 || integ !== 16'sd0 || ctrl_valid !== 1'b0 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: ctrl=%0d integ=%0d vld=%b sat=%b, required all 0", ctrl, integ, ctrl_valid, sat);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pi_accum();
        logic vm, v, s;
        logic signed [W-1:0] c, i;
        logic signed [W-1:0] exp_c [2] = '{16'sd6144, 16'sd8192};
        logic signed [W-1:0] exp_i [2] = '{16'sd2048, 16'sd4096};
        for (int k = 0; k < 2; k++) begin
            do_strobe(16'sd8192, 16'sd8192, 16'sd4096, 1'b0, 1'b0, vm, v, c, i, s);
            n_tests++;
            if (vm !== 1'b0 || v !== 1'b1) begin
                n_fail++;
                $display("FAIL pi_latency[%0d]: valid after 1/2 edges=%b/%b, required 0/1", k, vm, v);
            end
            n_tests++;
            if (c !== exp_c[k] || i !== exp_i[k] || s !== 1'b0) begin
                n_fail++;
                $display("FAIL pi_accum[%0d]: ctrl=%0d integ=%0d sat=%b, required %0d %0d 0", k, c, i, s, exp_c[k], exp_i[k]);
            end
        end
        @(negedge clk);
        n_tests++;
        if (ctrl_valid !== 1'b0 || ctrl !== 16'sd8192) begin
            n_fail++;
            $display("FAIL pi_hold: vld=%b ctrl=%0d, required 0 8192", ctrl_valid, ctrl);
        end
    endtask

    task automatic test_rounding();
        logic vm, v, s;
        logic signed [W-1:0] c, i;
        logic signed [W-1:0] e_tab [3] = '{16'sd1, -16'sd1, -16'sd8192};
        logic signed [W-1:0] x_tab [3] = '{16'sd1, 16'sd0, -16'sd4096};
        do_clear();
        for (int k = 0; k < 3; k++) begin
            do_strobe(e_tab[k], 16'sd8192, 16'sd0, 1'b0, 1'b0, vm, v, c, i, s);
            n_tests++;
            if (v !== 1'b1 || c !== x_tab[k] || i !== 16'sd0) begin
                n_fail++;
                $display("FAIL rounding[%0d]: vld=%b ctrl=%0d integ=%0d, required 1 %0d 0", k, v, c, i, x_tab[k]);
            end
        end
    endtask

    task automatic test_saturation();
        logic vm, v, s;
        logic signed [W-1:0] c, i;
        do_clear();
        for (int k = 0; k < 5; k++) begin
            do_strobe(16'sd32767, 16'sd32767, 16'sd32767, 1'b0, 1'b0, vm, v, c, i, s);
            n_tests++;
            if (c !== 16'sd32767 || s !== 1'b1 || i !== 16'sd32767) begin
                n_fail++;
                $display("FAIL saturation[%0d]: ctrl=%0d sat=%b integ=%0d, required 32767 1 32767", k, c, s, i);
            end
        end
        do_strobe(-16'sd8192, 16'sd8192, 16'sd0, 1'b0, 1'b0, vm, v, c, i, s);
        n_tests++;
        if (c !== 16'sd28671 || s !== 1'b0 || i !== 16'sd32767) begin
            n_fail++;
            $display("FAIL antiwindup: ctrl=%0d sat=%b integ=%0d, required 28671 0 32767", c, s, i);
        end
    endtask

    task automatic test_freeze_mode();
        logic vm, v, s;
        logic signed [W-1:0] c, i;
        do_clear();
        repeat (2) do_strobe(16'sd8192, 16'sd8192, 16'sd4096, 1'b0, 1'b0, vm, v, c, i, s);
        do_strobe(16'sd8192, 16'sd8192, 16'sd4096, 1'b0, 1'b1, vm, v, c, i, s);
        n_tests++;
        if (i !== 16'sd4096 || c !== 16'sd8192) begin
            n_fail++;
            $display("FAIL freeze: integ=%0d ctrl=%0d, required 4096 8192", i, c);
        end
        do_strobe(16'sd8192, 16'sd8192, 16'sd4096, 1'b1, 1'b0, vm, v, c, i, s);
        n_tests++;
        if (i !== 16'sd4096 || c !== 16'sd4096 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL prop_mode: integ=%0d ctrl=%0d vld=%b, required 4096 4096 1", i, c, v);
        end
        mode = 1'b0;
    endtask

    task automatic test_clear();
        logic vm, v, s;
        logic signed [W-1:0] c, i;
        @(negedge clk);
        clear = 1'b1; err_valid = 1'b1; freeze = 1'b1; err = 16'sd8192; c1 = 16'sd8192; c2 = 16'sd4096;
        @(negedge clk);
        clear = 1'b0; err_valid = 1'b0; freeze = 1'b0;
        n_tests++;
        if (ctrl_valid !== 1'b0 || ctrl !== 16'sd0 || integ !== 16'sd0 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_prio: vld=%b ctrl=%0d integ=%0d sat=%b, required 0 0 0 0", ctrl_valid, ctrl, integ, sat);
        end
        @(negedge clk);
        n_tests++;
        if (ctrl_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_drop: vld=%b, required 0", ctrl_valid);
        end
        @(negedge clk);
        err_valid = 1'b1;
        @(negedge clk);
        err_valid = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_tests++;
        if (ctrl_valid !== 1'b0 || ctrl !== 16'sd0) begin
            n_fail++;
            $display("FAIL clear_inflight: vld=%b ctrl=%0d, required 0 0", ctrl_valid, ctrl);
        end
        do_strobe(16'sd8192, 16'sd8192, 16'sd4096, 1'b0, 1'b0, vm, v, c, i, s);
        n_tests++;
        if (v !== 1'b1 || c !== 16'sd6144 || i !== 16'sd2048) begin
            n_fail++;
            $display("FAIL clear_restart: vld=%b ctrl=%0d integ=%0d, required 1 6144 2048", v, c, i);
        end
    endtask

    task automatic test_async_reset();
        bit saw_valid;
        @(negedge clk);
        err_valid = 1'b1; err = 16'sd8192; c1 = 16'sd8192; c2 = 16'sd4096;
        @(negedge clk);
        err_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (ctrl !== 16'sd0 || integ !== 16'sd0 || sat !== 1'b0 || ctrl_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: ctrl=%0d integ=%0d sat=%b vld=%b, required 0 0 0 0", ctrl, integ, sat, ctrl_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ctrl_valid !== 1'b0) saw_valid = 1'b1;
        end
        n_tests++;
        if (saw_valid || ctrl !== 16'sd0) begin
            n_fail++;
            $display("FAIL async_discard: saw_valid=%b ctrl=%0d, required 0 0", saw_valid, ctrl);
        end
    endtask

    task automatic test_back_to_back();
        longint mI = 0, pp1 = 0, pp2 = 0, t, s_sum;
        bit pv = 1'b0, ic, cc, gc;
        logic signed [W-1:0] ec = '0, ei = '0;
        logic ev = 1'b0, es = 1'b0;
        int bad = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            n_tests++;
            if (ctrl_valid !== ev || ctrl !== ec || integ !== ei || sat !== es) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL b2b[%0d]: vld=%b ctrl=%0d integ=%0d sat=%b, required %b %0d %0d %b",
                             cyc, ctrl_valid, ctrl, integ, sat, ev, ec, ei, es);
            end
            err_valid = ($urandom_range(0, 9) < 7);
            err       = W'($urandom);
            c1        = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 16383) - 8192);
            c2        = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 4095) - 2048);
            mode      = ($urandom_range(0, 7) == 0);
            freeze    = ($urandom_range(0, 7) == 0);
            clear     = ($urandom_range(0, 39) == 0);
            if (clear) begin
                mI = 0; pv = 1'b0; ec = '0; ei = '0; es = 1'b0; ev = 1'b0;
            end else begin
                if (pv) begin
                    ic = 1'b0;
                    if (!mode && !freeze) begin
                        t = mI + pp2;
                        if (t > I_MAX) begin t = I_MAX; ic = 1'b1; end
                        if (t < I_MIN) begin t = I_MIN; ic = 1'b1; end
                        mI = t;
                    end
                    s_sum = pp1 + (mode ? 64'sd0 : mI);
                    ec = W'(rnd_sat(s_sum, cc));
                    ei = W'(rnd_sat(mI, gc));
                    es = ic | cc | gc;
                    ev = 1'b1;
                end else begin
                    ev = 1'b0;
                end
                pv = err_valid;
                if (err_valid) begin
                    pp1 = longint'(c1) * longint'(err);
                    pp2 = longint'(c2) * longint'(err);
                end
            end
        end
        @(negedge clk);
        err_valid = 1'b0; clear = 1'b0; mode = 1'b0; freeze = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pi_accum();
        test_rounding();
        test_saturation();
        test_freeze_mode();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
